jlsemi_util_clkdiv_mon: RTL and testbench
=========================================

# jlsemi_util_clkdiv_mon

Receive-side checker for odd-ratio divided clocks. It samples a divided clock in the source clock domain and measures its period and high time in source-clock cycles. It declares lock after a run of in-tolerance periods and raises sticky errors on period, duty or stuck-clock faults. It sits beside each odd divider instance and feeds the register file status bits.

## Interface
- DIV_N, 25, expected division ratio (odd, ≥3)
- TOL, 1, allowed period deviation in cycles (±)
- LOCK_CNT, 4, consecutive good periods needed for lock (1–15)
- CW (localparam), $clog2(4*DIV_N), width of measurement counters

Ports:
- clk_in_pre  in  1  source clock (decided: clock clk_in_pre)
- rstn_out  in  1  reset (decided: rstn_out, asynchronous, active-low)
- mon_en  in  1  monitor enable; low forces IDLE
- clk_div_in  in  1  divided clock under test, synchronised internally
- clr_sticky  in  1  one-cycle pulse; clears err_period, err_duty, err_cnt
- lock  out  1  divided clock is in tolerance
- lock_lost  out  1  one-cycle pulse on the LOCKED→MEASURE transition
- err_period  out  1  sticky; period out of tolerance, or timeout
- err_duty  out  1  sticky; high time outside {(DIV_N-1)/2, (DIV_N+1)/2}
- err_cnt  out  8  saturating count of error events
- period_meas  out  CW  last completed period, in cycles
- high_meas  out  CW  last completed high time, in cycles

## Operation
- 2-flop synchroniser, then edge detect: rise/fall flags valid 3 cycles after the input edge.
- Period counter: loads 1 on a detected rise, otherwise increments; saturates at 2^CW-1.
- High counter: loads 1 on rise, increments while the synchronised level is 1.
- On each rise after the first: period_meas ← period counter. On each fall: high_meas ← high counter.
- Good period: |period_meas − DIV_N| ≤ TOL.
- FSM states:
  - IDLE: entered whenever mon_en=0. Counters and good-count cleared. lock=0. Sticky flags held.
  - WAIT_EDGE: mon_en=1. Waits for the first rise, then MEASURE.
  - MEASURE: each good period increments good-count. A bad period clears good-count, sets err_period and increments err_cnt. good-count = LOCK_CNT → LOCKED.
  - LOCKED: lock=1. A bad period or timeout → MEASURE with lock_lost=1 for one cycle, err_period set, err_cnt +1.
- Timeout: period counter reaches 2*DIV_N+TOL with no rise (in MEASURE or LOCKED) → counts as a bad period. Counter restarts at 1; one error per timeout interval.
- err_cnt saturates at 255.
- A period error and a duty error in the same cycle count once.
- clr_sticky coincident with a new error: the error wins (flag = 1, err_cnt = 1).

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- lock rises 1 cycle after the detected rise that completes the LOCK_CNT-th good period. With LOCK_CNT=4, that is after 5 detected rises.
- lock_lost, err_period and err_cnt all update 1 cycle after the offending detected rise or the timeout cycle.
- period_meas and high_meas update 1 cycle after the detected edge.
- mon_en falling: lock=0 on the next cycle; no lock_lost pulse.
- Reset asserted mid-operation: all state clears immediately (asynchronous).

## Configuration
- JLSEMI_CLKDIV_MON_DUTY_CHK_EN
  - Defined: high counter, high_meas and err_duty are implemented. A duty error also increments err_cnt.
  - Undefined: high_meas and err_duty tied 0; no high counter flops.

## Structure
- Shared package jlsemi_util_clkdiv_pkg holds:
  - FSM state encodings: IDLE=2'd0, WAIT_EDGE=2'd1, MEASURE=2'd2, LOCKED=2'd3.
  - ERR_CNT_W=8.
  - The width function for CW.
- Sub-module jlsemi_util_sync_edge_det: N-stage synchroniser plus rise/fall pulse outputs; reused by other monitors.

## Test plan
- DIV_N=25, nominal divider output, mon_en=1 → period_meas=25; high_meas ∈ {12,13}; lock=1 one cycle after the 5th detected rise; err_* = 0.
- After lock, one 27-cycle period → lock_lost pulse, lock=0, err_period=1, err_cnt=1; lock returns after 4 further good periods.
- After lock, clk_div_in held low → timeout at 51 cycles after the last rise; err_period=1; err_cnt increments every 51 cycles.
- 25-cycle period with 10-cycle high → err_duty=1 with the macro defined; err_duty=0 and lock=1 without it.
- clr_sticky in the same cycle as a new period error → err_period=1, err_cnt=1. clr_sticky alone afterwards → all sticky outputs 0.
- Reset asserted while LOCKED → every output 0 immediately. After release, lock re-acquired after 5 rises.

Source files
------------

// File: rtl/jlsemi_util_clkdiv_pkg.sv
// jlsemi_util_clkdiv_pkg: shared types and helpers for the odd-divider clock monitors.
`default_nettype none

package jlsemi_util_clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        LOCKED    = 2'd3
    } mon_state_e;

    localparam int ERR_CNT_W = 8;

    // Counter width leaves headroom above the 2*DIV_N+TOL timeout value.
    function automatic int clkdiv_cnt_width(input int div_n);
        return $clog2(4 * div_n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jlsemi_util_sync_edge_det.sv
// jlsemi_util_sync_edge_det: STAGES-flop synchroniser (STAGES >= 2) with registered
// rise/fall pulses; level_o is delayed one stage so it lines up with the pulses.
`default_nettype none

module jlsemi_util_sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_in_pre,
    input  logic rstn_out,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

`default_nettype wire

// File: rtl/jlsemi_util_clkdiv_mon.sv
// jlsemi_util_clkdiv_mon: period/duty/lock checker for an odd-ratio divided clock.
// Duty checking is built only when JLSEMI_CLKDIV_MON_DUTY_CHK_EN is defined.
`default_nettype none

module jlsemi_util_clkdiv_mon
    import jlsemi_util_clkdiv_pkg::*;
#(
    parameter  int DIV_N    = 25,
    parameter  int TOL      = 1,
    parameter  int LOCK_CNT = 4,
    localparam int CW       = clkdiv_cnt_width(DIV_N)
) (
    input  logic                 clk_in_pre,
    input  logic                 rstn_out,
    input  logic                 mon_en,
    input  logic                 clk_div_in,
    input  logic                 clr_sticky,
    output logic                 lock,
    output logic                 lock_lost,
    output logic                 err_period,
    output logic                 err_duty,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CW-1:0]        period_meas,
    output logic [CW-1:0]        high_meas
);

    localparam logic [CW-1:0]        CNT_MAX = '1;
    localparam logic [CW-1:0]        TMO_CNT = CW'(2 * DIV_N + TOL);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    mon_state_e           state_q, state_d;
    logic [3:0]           good_q, good_d;
    logic                 lock_lost_q, lock_lost_d;
    logic [CW-1:0]        per_cnt_q;
    logic [CW-1:0]        period_meas_q;
    logic                 err_period_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic w_level, w_rise, w_fall;
    logic w_active, w_timeout, w_per_eval, w_good, w_per_err, w_duty_err, w_new_err;

    jlsemi_util_sync_edge_det #(
        .STAGES (2)
    ) u_sync_edge (
        .clk_in_pre (clk_in_pre),
        .rstn_out   (rstn_out),
        .d_i        (clk_div_in),
        .level_o    (w_level),
        .rise_o     (w_rise),
        .fall_o     (w_fall)
    );

    assign w_active   = mon_en && (state_q == MEASURE || state_q == LOCKED);
    assign w_timeout  = w_active && !w_rise && (per_cnt_q == TMO_CNT);
    assign w_per_eval = w_active && w_rise;
    assign w_good     = (int'(per_cnt_q) >= DIV_N - TOL) && (int'(per_cnt_q) <= DIV_N + TOL);
    assign w_per_err  = (w_per_eval && !w_good) || w_timeout;
    assign w_new_err  = w_per_err || w_duty_err;

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        lock_lost_d = 1'b0;
        if (!mon_en) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_EDGE;
                WAIT_EDGE: if (w_rise) state_d = MEASURE;
                MEASURE: begin
                    if (w_per_err) begin
                        good_d = '0;
                    end else if (w_per_eval) begin
                        if (good_q == 4'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_per_err) begin
                        state_d     = MEASURE;
                        lock_lost_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            state_q     <= IDLE;
            good_q      <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // A timeout restarts the count so that each further silent interval errors once.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            per_cnt_q     <= '0;
            period_meas_q <= '0;
        end else begin
            if (!mon_en || state_q == IDLE) begin
                per_cnt_q <= '0;
            end else if (w_rise || w_timeout) begin
                per_cnt_q <= CW'(1);
            end else if (per_cnt_q != CNT_MAX) begin
                per_cnt_q <= per_cnt_q + CW'(1);
            end
            if (w_per_eval) begin
                period_meas_q <= per_cnt_q;
            end
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            err_period_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            if (w_per_err) begin
                err_period_q <= 1'b1;
            end else if (clr_sticky) begin
                err_period_q <= 1'b0;
            end
            if (w_new_err) begin
                if (clr_sticky) begin
                    err_cnt_q <= ERR_CNT_W'(1);
                end else if (err_cnt_q != ERR_MAX) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end else if (clr_sticky) begin
                err_cnt_q <= '0;
            end
        end
    end

`ifdef JLSEMI_CLKDIV_MON_DUTY_CHK_EN
    localparam logic [CW-1:0] HI_LO = CW'((DIV_N - 1) / 2);
    localparam logic [CW-1:0] HI_HI = CW'((DIV_N + 1) / 2);

    logic [CW-1:0] hi_cnt_q;
    logic [CW-1:0] high_meas_q;
    logic          err_duty_q;

    assign w_duty_err = w_active && w_fall && (hi_cnt_q != HI_LO) && (hi_cnt_q != HI_HI);

    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            hi_cnt_q    <= '0;
            high_meas_q <= '0;
            err_duty_q  <= 1'b0;
        end else begin
            if (!mon_en || state_q == IDLE) begin
                hi_cnt_q <= '0;
            end else if (w_rise) begin
                hi_cnt_q <= CW'(1);
            end else if (w_level && hi_cnt_q != CNT_MAX) begin
                hi_cnt_q <= hi_cnt_q + CW'(1);
            end
            if (w_active && w_fall) begin
                high_meas_q <= hi_cnt_q;
            end
            if (w_duty_err) begin
                err_duty_q <= 1'b1;
            end else if (clr_sticky) begin
                err_duty_q <= 1'b0;
            end
        end
    end

    assign high_meas = high_meas_q;
    assign err_duty  = err_duty_q;
`else
    logic duty_chk_unused;

    assign duty_chk_unused = w_level ^ w_fall;
    assign w_duty_err      = 1'b0;
    assign high_meas       = '0;
    assign err_duty        = 1'b0;
`endif

    assign lock        = (state_q == LOCKED);
    assign lock_lost   = lock_lost_q;
    assign err_period  = err_period_q;
    assign err_cnt     = err_cnt_q;
    assign period_meas = period_meas_q;

endmodule

`default_nettype wire

// File: tb/tb_jlsemi_util_clkdiv_mon.sv
// tb_jlsemi_util_clkdiv_mon: scenario tasks plus randomized periods against a
// cycle-count reference model of lock, sticky errors and measurements.
`default_nettype none

module tb_jlsemi_util_clkdiv_mon;

    localparam int DIV_N    = 25;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int CW       = $clog2(4 * DIV_N);

    logic          clk_in_pre = 1'b0;
    logic          rstn_out   = 1'b0;
    logic          mon_en     = 1'b0;
    logic          clk_div_in = 1'b0;
    logic          clr_sticky = 1'b0;
    logic          lock, lock_lost, err_period, err_duty;
    logic [7:0]    err_cnt;
    logic [CW-1:0] period_meas, high_meas;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ll_seen = 0;

    // reference model state
    int m_last_rise, m_run, m_cnt, m_per, m_hi, m_ll;
    bit m_seen, m_lock, m_eper, m_eduty;

    jlsemi_util_clkdiv_mon #(
        .DIV_N    (DIV_N),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk_in_pre  (clk_in_pre),
        .rstn_out    (rstn_out),
        .mon_en      (mon_en),
        .clk_div_in  (clk_div_in),
        .clr_sticky  (clr_sticky),
        .lock        (lock),
        .lock_lost   (lock_lost),
        .err_period  (err_period),
        .err_duty    (err_duty),
        .err_cnt     (err_cnt),
        .period_meas (period_meas),
        .high_meas   (high_meas)
    );

    always #5 clk_in_pre = ~clk_in_pre;

    always @(negedge clk_in_pre) if (lock_lost === 1'b1) ll_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in_pre);
        #1;
        cyc++;
    endtask

    task automatic model_restart();
        m_seen = 0; m_run = 0; m_lock = 0;
    endtask

    task automatic model_clear_all();
        model_restart();
        m_eper = 0; m_eduty = 0; m_cnt = 0; m_per = 0; m_hi = 0;
    endtask

    // Drive a rising edge and judge the period that it closes.
    task automatic model_rise();
        int p;
        if (m_seen) begin
            p     = cyc - m_last_rise;
            m_per = p;
            if (p >= DIV_N - TOL && p <= DIV_N + TOL) begin
                m_run++;
                if (m_run >= LOCK_CNT) m_lock = 1;
            end else begin
                if (m_lock) m_ll++;
                m_lock = 0; m_run = 0; m_eper = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        m_seen      = 1;
        m_last_rise = cyc;
        clk_div_in  = 1'b1;
    endtask

    task automatic model_fall();
`ifdef JLSEMI_CLKDIV_MON_DUTY_CHK_EN
        int h;
        h    = cyc - m_last_rise;
        m_hi = h;
        if (h != (DIV_N - 1) / 2 && h != (DIV_N + 1) / 2) begin
            m_eduty = 1;
            if (m_cnt < 255) m_cnt++;
        end
`endif
        clk_div_in = 1'b0;
    endtask

    task automatic drive_period(input int hi, input int per);
        model_rise();
        repeat (hi) tick();
        model_fall();
        repeat (per - hi) tick();
    endtask

    task automatic test_reset();
        rstn_out = 1'b0; mon_en = 1'b0; clk_div_in = 1'b0; clr_sticky = 1'b0;
        repeat (3) tick();
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL rst_lock: got %b expected 0", lock); end
        n_vec++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL rst_lock_lost: got %b expected 0", lock_lost); end
        n_vec++; if (err_period !== 1'b0) begin n_err++; $display("FAIL rst_err_period: got %b expected 0", err_period); end
        n_vec++; if (err_duty !== 1'b0) begin n_err++; $display("FAIL rst_err_duty: got %b expected 0", err_duty); end
        n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
        n_vec++; if (period_meas !== '0) begin n_err++; $display("FAIL rst_period_meas: got %0d expected 0", period_meas); end
        n_vec++; if (high_meas !== '0) begin n_err++; $display("FAIL rst_high_meas: got %0d expected 0", high_meas); end
        rstn_out = 1'b1;
        model_clear_all();
        mon_en = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_nominal_lock();
        repeat (4) drive_period(12, 25);
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL nom_lock_pre: got %b expected 0", lock); end
        n_vec++; if (period_meas !== CW'(m_per)) begin n_err++; $display("FAIL nom_period_meas: got %0d expected %0d", period_meas, m_per); end
        n_vec++; if (high_meas !== CW'(m_hi)) begin n_err++; $display("FAIL nom_high_meas: got %0d expected %0d", high_meas, m_hi); end
        n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL nom_err_cnt: got %0d expected 0", err_cnt); end
        model_rise();
        repeat (3) tick();
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL nom_lock_early: got %b expected 0", lock); end
        tick();
        n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL nom_lock_edge: got %b expected 1", lock); end
        repeat (9) tick();
        model_fall();
        repeat (12) tick();
        n_vec++; if (period_meas !== CW'(25)) begin n_err++; $display("FAIL nom_period_25: got %0d expected 25", period_meas); end
        n_vec++; if (err_period !== 1'b0 || err_duty !== 1'b0) begin n_err++; $display("FAIL nom_errs: got %b%b expected 00", err_period, err_duty); end
    endtask

    task automatic test_period_error();
        drive_period(13, 27);
        drive_period(12, 25);
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL per_lock_drop: got %b expected 0", lock); end
        n_vec++; if (err_period !== 1'b1) begin n_err++; $display("FAIL per_err_period: got %b expected 1", err_period); end
        n_vec++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL per_err_cnt: got %0d expected 1", err_cnt); end
        n_vec++; if (period_meas !== CW'(27)) begin n_err++; $display("FAIL per_period_meas: got %0d expected 27", period_meas); end
        n_vec++; if (ll_seen !== 1) begin n_err++; $display("FAIL per_lock_lost: got %0d pulses expected 1", ll_seen); end
        repeat (3) drive_period(12, 25);
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL per_relock_early: got %b expected 0", lock); end
        drive_period(13, 25);
        n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL per_relock: got %b expected 1", lock); end
    endtask

    task automatic test_timeout();
        int base, ll0, e;
        base = m_cnt;
        ll0  = ll_seen;
        model_rise();
        for (int n = 1; n <= 110; n++) begin
            tick();
            if (n == 12) model_fall();
            e = base + (n >= 55 ? 1 : 0) + (n >= 106 ? 1 : 0);
            n_vec++; if (err_cnt !== 8'(e)) begin n_err++; $display("FAIL tmo_err_cnt n=%0d: got %0d expected %0d", n, err_cnt, e); end
            n_vec++; if (lock !== (n < 55)) begin n_err++; $display("FAIL tmo_lock n=%0d: got %b expected %b", n, lock, (n < 55)); end
        end
        n_vec++; if (err_period !== 1'b1) begin n_err++; $display("FAIL tmo_err_period: got %b expected 1", err_period); end
        n_vec++; if (ll_seen !== ll0 + 1) begin n_err++; $display("FAIL tmo_lock_lost: got %0d pulses expected %0d", ll_seen, ll0 + 1); end
        m_cnt = base + 2; m_eper = 1; m_lock = 0; m_run = 0; m_ll++;
        mon_en = 1'b0;
        repeat (2) tick();
        mon_en = 1'b1;
        model_restart();
        repeat (2) tick();
    endtask

    task automatic test_duty();
        repeat (6) drive_period(10, 25);
        n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL duty_lock: got %b expected 1", lock); end
        n_vec++; if (err_duty !== m_eduty) begin n_err++; $display("FAIL duty_err_duty: got %b expected %b", err_duty, m_eduty); end
        n_vec++; if (high_meas !== CW'(m_hi)) begin n_err++; $display("FAIL duty_high_meas: got %0d expected %0d", high_meas, m_hi); end
        n_vec++; if (err_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL duty_err_cnt: got %0d expected %0d", err_cnt, m_cnt); end
    endtask

    task automatic test_mon_en_drop();
        int ll0;
        ll0 = ll_seen;
        mon_en = 1'b0;
        tick();
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL drop_lock: got %b expected 0", lock); end
        tick();
        n_vec++; if (ll_seen !== ll0) begin n_err++; $display("FAIL drop_no_lock_lost: got %0d pulses expected %0d", ll_seen, ll0); end
        mon_en = 1'b1;
        model_restart();
        repeat (2) tick();
    endtask

    task automatic test_clr_sticky();
        drive_period(13, 27);
        model_rise();
        m_cnt = 1; m_eper = 1; m_eduty = 0;
        repeat (3) tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_vec++; if (err_period !== 1'b1) begin n_err++; $display("FAIL clr_coin_err_period: got %b expected 1", err_period); end
        n_vec++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL clr_coin_err_cnt: got %0d expected 1", err_cnt); end
        n_vec++; if (err_duty !== 1'b0) begin n_err++; $display("FAIL clr_coin_err_duty: got %b expected 0", err_duty); end
        repeat (4) tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        m_cnt = 0; m_eper = 0; m_eduty = 0;
        n_vec++; if ({err_period, err_duty} !== 2'b00) begin n_err++; $display("FAIL clr_alone_flags: got %b%b expected 00", err_period, err_duty); end
        n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL clr_alone_err_cnt: got %0d expected 0", err_cnt); end
        repeat (4) tick();
        model_fall();
        repeat (12) tick();
    endtask

    task automatic test_random();
        int per, hi;
        for (int i = 0; i < 40; i++) begin
            per = int'($urandom_range(28, 22));
            hi  = int'($urandom_range(14, 10));
            drive_period(hi, per);
            n_vec++; if (lock !== m_lock) begin n_err++; $display("FAIL rnd_lock i=%0d: got %b expected %b", i, lock, m_lock); end
            n_vec++; if (err_period !== m_eper) begin n_err++; $display("FAIL rnd_err_period i=%0d: got %b expected %b", i, err_period, m_eper); end
            n_vec++; if (err_duty !== m_eduty) begin n_err++; $display("FAIL rnd_err_duty i=%0d: got %b expected %b", i, err_duty, m_eduty); end
            n_vec++; if (err_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_err_cnt i=%0d: got %0d expected %0d", i, err_cnt, m_cnt); end
            n_vec++; if (period_meas !== CW'(m_per)) begin n_err++; $display("FAIL rnd_period_meas i=%0d: got %0d expected %0d", i, period_meas, m_per); end
            n_vec++; if (high_meas !== CW'(m_hi)) begin n_err++; $display("FAIL rnd_high_meas i=%0d: got %0d expected %0d", i, high_meas, m_hi); end
            n_vec++; if (ll_seen !== m_ll) begin n_err++; $display("FAIL rnd_lock_lost i=%0d: got %0d pulses expected %0d", i, ll_seen, m_ll); end
        end
    endtask

    task automatic test_reset_midop();
        repeat (5) drive_period(12, 25);
        n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL mid_lock_before: got %b expected 1", lock); end
        rstn_out = 1'b0;
        #2;
        n_vec++; if ({lock, lock_lost, err_period, err_duty} !== 4'b0000) begin n_err++; $display("FAIL mid_rst_flags: got %b%b%b%b expected 0000", lock, lock_lost, err_period, err_duty); end
        n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL mid_rst_err_cnt: got %0d expected 0", err_cnt); end
        n_vec++; if (period_meas !== '0 || high_meas !== '0) begin n_err++; $display("FAIL mid_rst_meas: got %0d/%0d expected 0/0", period_meas, high_meas); end
        repeat (2) tick();
        rstn_out = 1'b1;
        model_clear_all();
        repeat (2) tick();
        repeat (4) drive_period(12, 25);
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL mid_relock_pre: got %b expected 0", lock); end
        model_rise();
        repeat (3) tick();
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL mid_relock_early: got %b expected 0", lock); end
        tick();
        n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL mid_relock_edge: got %b expected 1", lock); end
        repeat (8) tick();
        model_fall();
        repeat (13) tick();
        n_vec++; if (err_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL mid_err_cnt: got %0d expected %0d", err_cnt, m_cnt); end
    endtask

    initial begin
        m_ll = 0;
        model_clear_all();
        test_reset();
        test_nominal_lock();
        test_period_error();
        test_timeout();
        test_duty();
        test_mon_en_drop();
        test_clr_sticky();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
